// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler: grants one of four requesters the shared W-bit mux
// for a fixed dwell period and routes the owner's word to LEDG.
module mux_rr_scheduler #(
  parameter int DWELL = 50_000_000,
  parameter int W     = 3
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] src_data,
  output logic [1:0]     sel,
  output logic [3:0]     gnt,
  output logic [W-1:0]   LEDG,
  output logic           busy,
  output logic           gnt_chg
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_chg_q, gnt_chg_d;

  logic          found;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic [W-1:0]  words [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign words[gi] = src_data[W*gi +: W];
    end
  endgenerate

  // Walk offsets 4..1 so the smallest offset from last_q (last+1 first) wins.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = last_q + 2'(i);
      if (req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gnt_chg_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = GRANT;
          sel_d     = win;
          gnt_d     = 4'b0001 << win;
          last_d    = win;
          cnt_d     = CW'(DWELL - 1);
          gnt_chg_d = 1'b1;
        end
      end
      GRANT: begin
        if (req[sel_q] && (cnt_q != '0)) begin
          cnt_d = cnt_q - CW'(1);
        end else if (found) begin
          sel_d     = win;
          gnt_d     = 4'b0001 << win;
          last_d    = win;
          cnt_d     = CW'(DWELL - 1);
          gnt_chg_d = 1'b1;
        end else begin
          // sel keeps its last value so the mux code stays stable while idle
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= 2'd0;
      gnt_q     <= 4'd0;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      gnt_chg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gnt_chg_q <= gnt_chg_d;
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = (state_q == GRANT);
  assign gnt_chg = gnt_chg_q;
  assign LEDG    = busy ? words[sel_q] : '0;

endmodule

// File: doc/mux_rr_scheduler.md
# mux_rr_scheduler

Round-robin scheduler that shares the 3-bit, 4-source switch multiplexer datapath among four requesters. Each source raises a request bit. The scheduler grants one source at a time for a fixed dwell period and drives the multiplexer select code. It routes the granted source's 3-bit word to the green LEDs. It sits between the board switches or client logic and the LED display path, replacing manual select switches with timed, fair arbitration.

## Interface
Parameters:
- DWELL, default 50_000_000: grant length in clock cycles (1 s at 50 MHz). Legal range is ≥1; benches use 4.
- W, default 3: data width per source.

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  4  request per source; req[k] belongs to source k.
- src_data  in  4*W  source words; source k occupies bits [W*k+W-1 : W*k].
- sel  out  2  registered multiplexer select code of the current grant.
- gnt  out  4  registered one-hot grant; all zero when idle.
- LEDG  out  W  selected source word; zero when idle.
- busy  out  1  high while in GRANT.
- gnt_chg  out  1  one-cycle registered pulse on every new grant, including a re-grant to the same source.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one source owns the mux.
- Registered state:
  - state
  - sel
  - gnt
  - last (2-bit pointer of the most recent grant)
  - cnt, the dwell down-counter, width clog2(DWELL) with a minimum of 1 bit
  - gnt_chg
- Round-robin pick: search req starting at last+1, then last+2, last+3, last, all modulo 4. The first asserted bit wins. A sole requester therefore re-wins repeatedly.
- IDLE:
  - If no req bit is set, remain in IDLE.
  - If any req bit is set, pick a winner w. Set sel=w, gnt=1<<w, last=w, cnt=DWELL-1, gnt_chg=1, and go to GRANT.
- GRANT, each cycle:
  - If req[sel]=1 and cnt≠0: decrement cnt. No other change.
  - If cnt=0 (dwell expired) or req[sel]=0 (early release): re-arbitrate over the current req using the same round-robin pick.
    - If a winner exists, load it exactly as from IDLE and stay in GRANT.
    - If no winner exists, go to IDLE with gnt=0 and sel holding its last value.
  - Expiry and release in the same cycle: treated as one re-arbitration, no double step.
- LEDG is combinational from the registered sel/state: src_data slice [sel] when busy=1, else 0. Source data changes propagate with zero latency during a grant.
- busy = (state==GRANT).
- gnt_chg is high only in the cycle after a grant load; otherwise 0.

## Timing
- Reset values, applied at the edge where reset=1, overriding all other activity including mid-grant:
  - state=IDLE
  - sel=0
  - gnt=0
  - last=3, so the first pick after reset favours source 0
  - cnt=0
  - gnt_chg=0
  - busy=0
  - LEDG=0
- Request-to-grant latency: req sampled at edge N, so gnt/sel/busy are valid after edge N, one cycle. No combinational path from req to gnt.
- Held grant length: exactly DWELL cycles when the owner keeps req high. The next owner's gnt appears in the following cycle with no idle gap.
- Release latency: owner drops req before edge N, so the owner's gnt clears after edge N.
- DWELL=1: cnt is always 0, and the scheduler re-arbitrates every cycle.
- Fairness: with all four requesting continuously, grants run 0,1,2,3,0,… with each source getting DWELL cycles.
- Changes to req[k] for k≠sel during a grant have no effect until re-arbitration.

## Test plan
All scenarios use DWELL=4 and src_data = {3'd7,3'd5,3'd3,3'd1}.
- Reset: hold reset=1 for 2 cycles with req=4'b1111, then release → gnt=0, busy=0, LEDG=0 while reset is asserted. The first edge after release gives gnt=4'b0001, sel=0, LEDG=1, gnt_chg=1 for one cycle.
- Full rotation: req=4'b1111 held → gnt sequence 0001,0010,0100,1000,0001, each held exactly 4 cycles. LEDG follows 1,3,5,7.
- Sole requester plus early release:
  - req=4'b0100 → gnt=0100 for 4 cycles, then re-granted to 0100 with gnt_chg pulsing at each 4-cycle boundary.
  - Drop req after 2 cycles → gnt=0, busy=0 one edge later.
- Skip and simultaneous event: grant source 1 with req=4'b1010, then drop req[1] in the same cycle cnt reaches 0 → the next grant is source 3, as a single transition.
- Reset mid-grant: assert reset while gnt=0010 → all outputs return to reset values one edge later. With req=4'b0010 after release, the grant goes to source 1 because the pointer was reset.
